disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000: clk cycles per digit slot; legal range is at least 2.
REQ-002 SHALL have parameter ROTATE_FRAMES, default 2000: completed frames per source in auto-rotate mode; legal range is at least 1.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port sw_sel  in  3  manual display-source select from board switches.
REQ-006 SHALL have port auto_en  in  1  requests auto-rotate through the display sources.
REQ-007 SHALL have port disp_data  in  32  value returned by the display-source selector.
REQ-008 SHALL have port src_sel  out  3  selector code driven to the display-source mux.
REQ-009 SHALL have port an  out  8  active-low digit enables; an[0] is the rightmost digit.
REQ-010 SHALL have port seg  out  8  active-low segments, ordered {dp,g,f,e,d,c,b,a}.
REQ-011 SHALL have port frame_tick  out  1  one-cycle pulse at the end of each 8-digit frame.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; the wrap cycle is the "slot edge".
REQ-013 Digit index d (0..7) SHALL be updated at each slot edge: an/seg are loaded with digit d's pattern, then d increments modulo 8.
REQ-014 Digit d SHALL display nibble disp_data[4d+3:4d] as hex 0-F; digit 0 is the least-significant nibble.
REQ-015 At the slot edge with d=0, shadow SHALL be loaded from disp_data; digit 0 decodes disp_data directly, and digits 1-7 decode shadow, so each frame is consistent.
REQ-016 an SHALL equal ~(8'b1<<d_loaded); exactly one bit is low after the first slot edge.
REQ-017 frame_tick SHALL be high for exactly the one cycle following the slot edge that loads d=7.
REQ-018 dp (seg[7]) SHALL be low only on digit 0 while in the ROTATE state, and high otherwise.
REQ-019 src_sel SHALL be registered; in MANUAL it follows sw_sel with one-cycle latency.
REQ-020 The FSM SHALL have states MANUAL and ROTATE.
REQ-021 MANUAL->ROTATE SHALL occur on the first edge with auto_en=1; src_sel becomes 3'b001 and the frame counter clears.
REQ-022 In ROTATE, after ROTATE_FRAMES frame_ticks, src_sel SHALL advance 1->2->3->4->5->6->0->1 and the frame counter clears.
REQ-023 ROTATE->MANUAL SHALL occur on the first edge with auto_en=0; src_sel becomes sw_sel. Changes to sw_sel are ignored while in ROTATE.
REQ-024 Code 3'b111 SHALL never be produced in ROTATE; in MANUAL, sw_sel=3'b111 passes through unchanged.

Reset
REQ-025 Asserting reset SHALL immediately force an=8'hFF, seg=8'hFF, src_sel=3'b000, frame_tick=0, prescaler=0, d=0, shadow=0, frame counter=0, and state=MANUAL.
REQ-026 After deassertion, the first slot edge SHALL occur SCAN_DIV cycles later and show digit 0.

Configuration
REQ-027 With macro DISP_AUTO_ROTATE_EN defined, the FSM and frame counter SHALL be present as specified above.
REQ-028 With DISP_AUTO_ROTATE_EN undefined, auto_en SHALL be ignored, src_sel SHALL be sw_sel registered, dp SHALL stay high, and the ROTATE_FRAMES parameter SHALL be unused.

Structure
REQ-029 Package disp_pkg SHALL hold:
- the source codes SEL_SYSCALL=0, SEL_PC=1, SEL_CYCLES=2, SEL_JCNT=3, SEL_BSUCC=4, SEL_LOADUSE=5, SEL_MDATA=6;
- the FSM state enum;
- the 16-entry hex-to-segment table.
REQ-030 A single combinational sub-module, hex7seg (4-bit nibble in, 7-bit active-low segments out), SHALL be instantiated once.

Verification (SCAN_DIV=4, ROTATE_FRAMES=2)
REQ-031 Reset asserted mid-frame SHALL immediately give an=8'hFF, seg=8'hFF, src_sel=000; after release, the first change SHALL occur 4 cycles later.
REQ-032 Manual mode, disp_data=32'h1234_5678: slot 1 SHALL give an=8'hFE, seg=8'h80 ('8'); slot 2 SHALL give an=8'hFD, seg=8'hF8 ('7'); slot 8 SHALL give an=8'h7F, seg=8'hF9 ('1'), with a frame_tick pulse.
REQ-033 disp_data changed to 32'hFFFF_FFFF while d=3 SHALL leave digits 3-7 showing the old value; all digits SHALL show 'F' (8'h8E) from the next frame.
REQ-034 auto_en=1 SHALL give src_sel=001 one cycle later, then 010 after 2 frame_ticks, and 000 after 12 frame_ticks, then 001 after 14 frame_ticks; dp SHALL be low on digit 0.
REQ-035 With sw_sel=101, dropping auto_en SHALL give src_sel=101 on the next cycle and dp high.
REQ-036 A build without DISP_AUTO_ROTATE_EN, auto_en=1, sw_sel=011 SHALL hold src_sel=011 for 20 frames.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared definitions for the display scan controller: source-select codes, FSM states
// and the hex-to-seven-segment table.
package disp_pkg;

   localparam logic [2:0] SEL_SYSCALL = 3'd0;
   localparam logic [2:0] SEL_PC      = 3'd1;
   localparam logic [2:0] SEL_CYCLES  = 3'd2;
   localparam logic [2:0] SEL_JCNT    = 3'd3;
   localparam logic [2:0] SEL_BSUCC   = 3'd4;
   localparam logic [2:0] SEL_LOADUSE = 3'd5;
   localparam logic [2:0] SEL_MDATA   = 3'd6;

   typedef enum logic {
      StManual,
      StRotate
   } disp_state_e;

   // Active-low {g,f,e,d,c,b,a}, indexed by nibble value (entry 15 listed first).
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
   import disp_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = HEX_SEG[nibble_i];
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with optional auto-rotation of the display
// source; rotation (FSM + frame counter) is built only when DISP_AUTO_ROTATE_EN is defined.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV      = 100000,
   parameter int unsigned ROTATE_FRAMES = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  sw_sel,
   input  logic        auto_en,
   input  logic [31:0] disp_data,
   output logic [2:0]  src_sel,
   output logic [7:0]  an,
   output logic [7:0]  seg,
   output logic        frame_tick
);

   localparam int unsigned DivW = $clog2(SCAN_DIV);

   logic [DivW-1:0] div_q, div_d;
   logic [2:0]      dig_q, dig_d;
   logic [31:0]     shadow_q, shadow_d;
   logic [7:0]      an_q, an_d;
   logic [7:0]      seg_q, seg_d;
   logic            frame_tick_q, frame_tick_d;
   logic [2:0]      src_sel_q, src_sel_d;

   logic       slot_edge;
   logic [3:0] nibble;
   logic [6:0] seg7;
   logic       rotating;

   assign slot_edge = (div_q == DivW'(SCAN_DIV - 1));

   // Digit 0 reads live data; the rest read the snapshot taken at digit 0.
   assign nibble = (dig_q == 3'd0) ? disp_data[3:0] : shadow_q[{dig_q, 2'b00} +: 4];

   hex7seg u_hex7seg (
      .nibble_i (nibble),
      .seg_o    (seg7)
   );

   always_comb begin
      div_d        = slot_edge ? '0 : div_q + 1'b1;
      dig_d        = dig_q;
      shadow_d     = shadow_q;
      an_d         = an_q;
      seg_d        = seg_q;
      frame_tick_d = 1'b0;
      if (slot_edge) begin
         an_d         = ~(8'b1 << dig_q);
         seg_d        = {~(rotating && (dig_q == 3'd0)), seg7};
         dig_d        = dig_q + 3'd1;
         frame_tick_d = (dig_q == 3'd7);
         if (dig_q == 3'd0) begin
            shadow_d = disp_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q        <= '0;
         dig_q        <= 3'd0;
         shadow_q     <= 32'h0;
         an_q         <= 8'hFF;
         seg_q        <= 8'hFF;
         frame_tick_q <= 1'b0;
         src_sel_q    <= SEL_SYSCALL;
      end else begin
         div_q        <= div_d;
         dig_q        <= dig_d;
         shadow_q     <= shadow_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_tick_q <= frame_tick_d;
         src_sel_q    <= src_sel_d;
      end
   end

`ifdef DISP_AUTO_ROTATE_EN
   localparam int unsigned CntW = $clog2(ROTATE_FRAMES + 1);

   disp_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign rotating = (state_q == StRotate);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      src_sel_d = src_sel_q;
      unique case (state_q)
         StManual: begin
            if (auto_en) begin
               state_d   = StRotate;
               src_sel_d = SEL_PC;
               cnt_d     = '0;
            end else begin
               src_sel_d = sw_sel;
            end
         end
         StRotate: begin
            if (!auto_en) begin
               state_d   = StManual;
               src_sel_d = sw_sel;
            end else if (frame_tick_q) begin
               if (cnt_q == CntW'(ROTATE_FRAMES - 1)) begin
                  cnt_d     = '0;
                  src_sel_d = (src_sel_q == SEL_MDATA) ? SEL_SYSCALL : src_sel_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StManual;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StManual;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
`else
   // Rotation absent: auto_en and ROTATE_FRAMES are intentionally left dangling.
   logic        unused_auto_en;
   logic [31:0] unused_rotate_frames;
   assign unused_auto_en       = auto_en;
   assign unused_rotate_frames = ROTATE_FRAMES;
   assign rotating             = 1'b0;

   always_comb begin
      src_sel_d = sw_sel;
   end
`endif

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_tick = frame_tick_q;
   assign src_sel    = src_sel_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: a cycle-level reference model queues expected digit
// loads, frame ticks and source codes; a negedge monitor pops and compares them.
module tb_disp_scan_ctrl;

   localparam int unsigned SCAN_DIV      = 4;
   localparam int unsigned ROTATE_FRAMES = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [2:0]  sw_sel = 3'd0;
   logic        auto_en = 1'b0;
   logic [31:0] disp_data = 32'h0;
   logic [2:0]  src_sel;
   logic [7:0]  an;
   logic [7:0]  seg;
   logic        frame_tick;

   disp_scan_ctrl #(
      .SCAN_DIV      (SCAN_DIV),
      .ROTATE_FRAMES (ROTATE_FRAMES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_sel     (sw_sel),
      .auto_en    (auto_en),
      .disp_data  (disp_data),
      .src_sel    (src_sel),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Segment patterns written active-high {g..a}, inverted for the active-low outputs.
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] on;
      case (n)
         4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
         4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
         4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
         4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
      endcase
      return ~on;
   endfunction

   typedef struct {
      logic [7:0]  an;
      logic [7:0]  seg;
      int unsigned at;
   } slot_t;

   slot_t       exp_q[$];
   int unsigned tick_q[$];
   logic [2:0]  src_q[$];

   // Reference model state.
   int unsigned cyc = 0;
   int unsigned slot = 0;
   logic [31:0] snap = 32'h0;
   bit          rot = 1'b0;
   logic [2:0]  src = 3'd0;
   int unsigned frames = 0;
   bit          tick_pending = 1'b0;

   initial begin : model
      int unsigned dg;
      bit          was_rot;
      bit          tick_seen;
      logic [3:0]  nib;
      slot_t       e;
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            cyc = 0; slot = 0; snap = 32'h0; rot = 1'b0; src = 3'd0;
            frames = 0; tick_pending = 1'b0;
            exp_q.delete(); tick_q.delete(); src_q.delete();
         end else begin
            was_rot      = rot;
            tick_seen    = tick_pending;
            tick_pending = 1'b0;
            cyc++;
            if (cyc % SCAN_DIV == 0) begin
               dg = slot % 8;
               if (dg == 0) begin
                  snap = disp_data;
                  nib  = disp_data[3:0];
               end else begin
                  nib = snap[4*dg +: 4];
               end
               e.an  = ~(8'(1) << dg);
               e.seg = {~(was_rot && dg == 0), seg_of(nib)};
               e.at  = cyc;
               exp_q.push_back(e);
               if (dg == 7) begin
                  tick_q.push_back(cyc);
                  tick_pending = 1'b1;
               end
               slot++;
            end
`ifdef DISP_AUTO_ROTATE_EN
            if (!was_rot) begin
               if (auto_en) begin
                  rot = 1'b1; src = 3'd1; frames = 0;
               end else begin
                  src = sw_sel;
               end
            end else if (!auto_en) begin
               rot = 1'b0; src = sw_sel;
            end else if (tick_seen) begin
               frames++;
               if (frames == ROTATE_FRAMES) begin
                  frames = 0;
                  src = (src == 3'd6) ? 3'd0 : src + 3'd1;
               end
            end
`else
            src = sw_sel;
`endif
            src_q.push_back(src);
         end
      end
   end

   logic [7:0] prev_an = 8'hFF;

   initial begin : monitor
      slot_t       e;
      int unsigned t;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev_an = 8'hFF;
         end else begin
            if (src_q.size() > 0) check("src_sel", 32'(src_sel), 32'(src_q.pop_front()));
            if (an !== prev_an) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_an_change", 32'(an), 32'(prev_an));
               end else begin
                  e = exp_q.pop_front();
                  check("slot_an", 32'(an), 32'(e.an));
                  check("slot_seg", 32'(seg), 32'(e.seg));
                  check("slot_cycle", cyc, e.at);
               end
               prev_an = an;
            end
            if (frame_tick === 1'b1) begin
               if (tick_q.size() == 0) begin
                  check("unexpected_frame_tick", 32'(frame_tick), 32'h0);
               end else begin
                  t = tick_q.pop_front();
                  check("frame_tick_cycle", cyc, t);
               end
            end
         end
      end
   end

   task automatic wait_ticks(input int n);
      int seen = 0;
      int budget = 0;
      while (seen < n && budget < 2000) begin
         @(posedge clk); #1;
         budget++;
         if (frame_tick === 1'b1) seen++;
      end
      if (seen < n) check("frame_tick_timeout", 32'(seen), 32'(n));
   endtask

   task automatic check_reset_state();
      check("rst_an", 32'(an), 32'hFF);
      check("rst_seg", 32'(seg), 32'hFF);
      check("rst_src_sel", 32'(src_sel), 32'h0);
      check("rst_frame_tick", 32'(frame_tick), 32'h0);
   endtask

   initial begin : stim
      disp_data = 32'h1234_5678;
      repeat (3) @(negedge clk);
      check_reset_state();
      reset = 1'b1;

      // First frame of known data with directed spot checks.
      repeat (3) @(posedge clk);
      #1 check("no_change_before_first_slot", 32'(an), 32'hFF);
      @(posedge clk);
      #1 check("slot1_an", 32'(an), 32'hFE);
      check("slot1_seg", 32'(seg), 32'h80);
      repeat (4) @(posedge clk);
      #1 check("slot2_an", 32'(an), 32'hFD);
      check("slot2_seg", 32'(seg), 32'hF8);
      repeat (24) @(posedge clk);
      #1 check("slot8_an", 32'(an), 32'h7F);
      check("slot8_seg", 32'(seg), 32'hF9);
      check("slot8_tick", 32'(frame_tick), 32'h1);

      // Change data mid-frame while d=3: remainder of frame keeps the snapshot.
      repeat (12) @(posedge clk);
      #1 disp_data = 32'hFFFF_FFFF;
      repeat (4) @(posedge clk);
      #1 check("midframe_d3_old", 32'(seg), 32'h92);
      repeat (16) @(posedge clk);
      #1 check("midframe_d7_old", 32'(seg), 32'hF9);
      repeat (4) @(posedge clk);
      #1 check("next_frame_F", 32'(seg), 32'h8E);

      // Random data and switch traffic in manual mode.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(1, 20)) @(negedge clk);
         disp_data = $urandom;
         if ($urandom_range(0, 3) == 0) sw_sel = 3'($urandom);
      end

      // Asynchronous reset in the middle of a frame.
      repeat ($urandom_range(5, 40)) @(negedge clk);
      #1 reset = 1'b0;
      #1 check_reset_state();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("post_reset_no_change", 32'(an), 32'hFF);
      @(posedge clk);
      #1 check("post_reset_first_digit", 32'(an), 32'hFE);

`ifdef DISP_AUTO_ROTATE_EN
      @(negedge clk);
      sw_sel  = 3'($urandom);
      auto_en = 1'b1;
      @(posedge clk);
      #1 check("rotate_entry", 32'(src_sel), 32'h1);
      wait_ticks(2);
      @(posedge clk);
      #1 check("rotate_after_2", 32'(src_sel), 32'h2);
      wait_ticks(10);
      @(posedge clk);
      #1 check("rotate_after_12", 32'(src_sel), 32'h0);
      wait_ticks(2);
      @(posedge clk);
      #1 check("rotate_after_14", 32'(src_sel), 32'h1);
      while (an !== 8'hFE) begin
         @(posedge clk); #1;
      end
      check("rotate_dp_digit0", 32'(seg[7]), 32'h0);
      @(negedge clk);
      sw_sel  = 3'b101;
      auto_en = 1'b0;
      @(posedge clk);
      #1 check("manual_return", 32'(src_sel), 32'h5);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         auto_en = ($urandom_range(0, 2) != 0);
         sw_sel  = 3'($urandom);
         for (int j = $urandom_range(1, 80); j > 0; j--) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) sw_sel = 3'($urandom);
            if ($urandom_range(0, 9) == 0) disp_data = $urandom;
         end
      end
      auto_en = 1'b0;
`else
      @(negedge clk);
      auto_en = 1'b1;
      sw_sel  = 3'b011;
      @(posedge clk);
      for (int i = 0; i < 20 * 8 * SCAN_DIV; i++) begin
         @(posedge clk);
         #1 check("no_rotate_src_hold", 32'(src_sel), 32'h3);
         if (an === 8'hFE) check("no_rotate_dp_high", 32'(seg[7]), 32'h1);
      end
      auto_en = 1'b0;
`endif

      repeat (2) @(negedge clk);
      #1;
      check("slot_queue_drained", 32'(exp_q.size()), 32'h0);
      check("tick_queue_drained", 32'(tick_q.size()), 32'h0);
      check("src_queue_drained", 32'(src_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
